// File: rtl/wheel_tick_accumulator_pkg.sv
// Shared position types: delta operand width, saturation limit and the
// accumulator state encoding used by the tick accumulator and the position adder.
package wheel_tick_accumulator_pkg;

  localparam int               DELTA_W   = 3;
  localparam logic [DELTA_W-1:0] DELTA_MAX = 3'd7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    PENDING = 2'd2
  } acc_state_e;

  typedef struct packed {
    logic [DELTA_W-1:0] value;
    logic               sat;
  } sat_sum_t;

  // Adds a single tick to a running count, pinning at DELTA_MAX.
  function automatic sat_sum_t sat_add(input logic [DELTA_W-1:0] a, input logic b);
    sat_sum_t r;
    if (b && (a == DELTA_MAX)) begin
      r.value = DELTA_MAX;
      r.sat   = 1'b1;
    end else begin
      r.value = a + {{(DELTA_W-1){1'b0}}, b};
      r.sat   = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/wheel_tick_accumulator_if.sv
// Valid/ready channel carrying the saturated tick delta to the position adder.
interface wheel_tick_accumulator_if;
  import wheel_tick_accumulator_pkg::*;

  logic [DELTA_W-1:0] delta;
  logic               delta_ovf;
  logic               delta_valid;
  logic               delta_ready;

  modport master (output delta, output delta_ovf, output delta_valid, input delta_ready);
  modport slave  (input delta, input delta_ovf, input delta_valid, output delta_ready);

endinterface

// File: rtl/wheel_tick_accumulator_tick_sync_edge.sv
// Synchronises an asynchronous pulse input and emits a registered one-cycle
// tick per rising edge; input edge to tick is SYNC_STAGES+1 cycles.
module tick_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic tick
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   tick_q, tick_d;

  // NOTE: every variable gets a value before any branch so no latch is inferred.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    prev_d = sync_q[SYNC_STAGES-1];
    tick_d = sync_q[SYNC_STAGES-1] & ~prev_q;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/wheel_tick_accumulator.sv
// Counts encoder ticks per fixed window and hands a saturated 3-bit delta to
// the position adder; ticks keep accumulating while the consumer stalls.
module wheel_tick_accumulator
  import wheel_tick_accumulator_pkg::*;
#(
  parameter int WINDOW_CYCLES = 50000,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enc_tick,
  input  logic                     enable,
  wheel_tick_accumulator_if.master out_if
);

  localparam int             CNT_W    = $clog2(WINDOW_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW_CYCLES - 1);

  acc_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DELTA_W-1:0] acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic [DELTA_W-1:0] delta_q, delta_d;
  logic               delta_ovf_q, delta_ovf_d;
  logic               valid_q, valid_d;

  logic     tick;
  logic     win_end;
  logic     slot_free;
  logic     transfer;
  sat_sum_t sum;

  tick_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (enc_tick),
    .tick     (tick)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    delta_d     = delta_q;
    delta_ovf_d = delta_ovf_q;
    valid_d     = valid_q;
    transfer    = 1'b0;

    sum       = sat_add(acc_q, tick);
    win_end   = (cnt_q == CNT_LAST);
    slot_free = !valid_q || out_if.delta_ready;

    if (valid_q && out_if.delta_ready) valid_d = 1'b0;

    // Disabling discards the partial window but leaves a held delta untouched.
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      acc_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = COUNT;
        COUNT, PENDING: begin
          cnt_d = win_end ? '0 : cnt_q + CNT_W'(1);
          acc_d = sum.value;
          ovf_d = ovf_q | sum.sat;
          if (state_q == PENDING) begin
            if (slot_free) begin
              transfer = 1'b1;
              state_d  = COUNT;
            end
          end else if (win_end) begin
            if (slot_free) transfer = 1'b1;
            else           state_d  = PENDING;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // The tick of the transfer cycle belongs to the value being handed off.
    if (transfer) begin
      delta_d     = sum.value;
      delta_ovf_d = ovf_q | sum.sat;
      valid_d     = 1'b1;
      acc_d       = '0;
      ovf_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      delta_q     <= '0;
      delta_ovf_q <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      delta_q     <= delta_d;
      delta_ovf_q <= delta_ovf_d;
      valid_q     <= valid_d;
    end
  end

  assign out_if.delta       = delta_q;
  assign out_if.delta_ovf   = delta_ovf_q;
  assign out_if.delta_valid = valid_q;

endmodule

// File: tb/tb_wheel_tick_accumulator.sv
// Scoreboard bench for wheel_tick_accumulator: an 8-cycle-window instance for
// most scenarios and a 32-cycle-window instance for saturation.
module tb_wheel_tick_accumulator;
  import wheel_tick_accumulator_pkg::*;

  typedef logic [DELTA_W:0] res_t;  // {delta_ovf, delta}

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic enc_tick = 1'b0;
  logic enable   = 1'b0;
  logic enable32 = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  res_t exp_q[$];
  res_t obs_q[$];
  res_t exp32_q[$];
  res_t obs32_q[$];

  bit prev_v = 1'b0, prev_hs = 1'b0, prev32_v = 1'b0, prev32_hs = 1'b0;

  wheel_tick_accumulator_if bus ();
  wheel_tick_accumulator_if bus32 ();

  always #5 clk = ~clk;

  wheel_tick_accumulator #(.WINDOW_CYCLES(8), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enc_tick (enc_tick),
    .enable   (enable),
    .out_if   (bus)
  );

  wheel_tick_accumulator #(.WINDOW_CYCLES(32), .SYNC_STAGES(2)) dut32 (
    .clk      (clk),
    .rst_n    (rst_n),
    .enc_tick (enc_tick),
    .enable   (enable32),
    .out_if   (bus32)
  );

  // Capture each newly presented delta: valid rising, or a reload right after a handshake.
  always @(negedge clk) begin
    if (rst_n && bus.delta_valid && (!prev_v || prev_hs))
      obs_q.push_back({bus.delta_ovf, bus.delta});
    if (rst_n && bus32.delta_valid && (!prev32_v || prev32_hs))
      obs32_q.push_back({bus32.delta_ovf, bus32.delta});
    prev_v    <= rst_n && bus.delta_valid;
    prev_hs   <= rst_n && bus.delta_valid && bus.delta_ready;
    prev32_v  <= rst_n && bus32.delta_valid;
    prev32_hs <= rst_n && bus32.delta_valid && bus32.delta_ready;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs, then land 1 time unit after the edge that samples them.
  task automatic cyc(input logic e, input logic en, input logic rdy, input logic en32);
    enc_tick        = e;
    enable          = en;
    bus.delta_ready = rdy;
    enable32        = en32;
    step();
  endtask

  task automatic idle();
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic drain(input string name, input bit wide);
    res_t e, o;
    int   n_exp, n_obs;
    n_exp = wide ? exp32_q.size() : exp_q.size();
    n_obs = wide ? obs32_q.size() : obs_q.size();
    n_cmp++;
    if (n_obs !== n_exp) begin
      n_bad++;
      $display("FAIL %s output_count: got %0d, expected %0d", name, n_obs, n_exp);
    end
    for (int i = 0; i < n_exp && i < n_obs; i++) begin
      e = wide ? exp32_q.pop_front() : exp_q.pop_front();
      o = wide ? obs32_q.pop_front() : obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL %s output[%0d]: got ovf=%0b delta=%0d, expected ovf=%0b delta=%0d",
                 name, i, o[DELTA_W], o[DELTA_W-1:0], e[DELTA_W], e[DELTA_W-1:0]);
      end
    end
    exp_q.delete(); obs_q.delete(); exp32_q.delete(); obs32_q.delete();
  endtask

  task automatic test_reset();
    bus.delta_ready   = 1'b1;
    bus32.delta_ready = 1'b1;
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if ({bus.delta_valid, bus.delta_ovf, bus.delta} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b, expected 00000", {bus.delta_valid, bus.delta_ovf, bus.delta});
    end
    n_cmp++;
    if (bus32.delta_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_valid32: got %b, expected 0", bus32.delta_valid);
    end
    step(); step();
    rst_n = 1'b1;
    idle();
  endtask

  task automatic test_basic_window();
    int d;
    exp_q.push_back({1'b0, 3'd3});
    for (int c = -1; c <= 8; c++) begin
      cyc(c == -1 || c == 1 || c == 3, c <= 7, 1'b1, 1'b0);
      d = c + 1;
      n_cmp++;
      if (d == 8) begin
        if ({bus.delta_valid, bus.delta_ovf, bus.delta} !== {1'b1, 1'b0, 3'd3}) begin
          n_bad++;
          $display("FAIL basic cycle %0d: got v/ovf/delta=%b, expected 10011", d,
                   {bus.delta_valid, bus.delta_ovf, bus.delta});
        end
      end else if (bus.delta_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL basic cycle %0d: got valid=%b, expected 0", d, bus.delta_valid);
      end
    end
    drain("basic", 1'b0);
    idle();
  endtask

  task automatic test_saturation();
    int d;
    exp32_q.push_back({1'b1, 3'd7});
    exp32_q.push_back({1'b0, 3'd0});
    for (int c = -1; c <= 64; c++) begin
      cyc(c >= -1 && c <= 17 && ((c + 1) % 2 == 0), 1'b0, 1'b1, c <= 63);
      d = c + 1;
      if (d == 32 || d == 64) begin
        n_cmp++;
        if ({bus32.delta_valid, bus32.delta_ovf, bus32.delta} !== ((d == 32) ? 5'b11111 : 5'b10000)) begin
          n_bad++;
          $display("FAIL saturation cycle %0d: got v/ovf/delta=%b, expected %b", d,
                   {bus32.delta_valid, bus32.delta_ovf, bus32.delta}, (d == 32) ? 5'b11111 : 5'b10000);
        end
      end else if (d == 33 || d == 65) begin
        n_cmp++;
        if (bus32.delta_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL saturation cycle %0d: got valid=%b, expected 0", d, bus32.delta_valid);
        end
      end
    end
    drain("saturation", 1'b1);
    idle();
  endtask

  task automatic test_stall_merge();
    int   d;
    logic e;
    exp_q.push_back({1'b0, 3'd2});
    exp_q.push_back({1'b0, 3'd4});
    for (int c = -1; c <= 19; c++) begin
      e = (c == -1 || c == 1 || c == 6 || c == 8 || c == 10 || c == 13);
      cyc(e, c <= 18, c >= 18, 1'b0);
      d = c + 1;
      n_cmp++;
      if (d <= 7 || d == 20) begin
        if (bus.delta_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL stall cycle %0d: got valid=%b, expected 0", d, bus.delta_valid);
        end
      end else if ({bus.delta_valid, bus.delta_ovf, bus.delta} !== {1'b1, 1'b0, (d == 19) ? 3'd4 : 3'd2}) begin
        n_bad++;
        $display("FAIL stall cycle %0d: got v/ovf/delta=%b, expected valid=1 delta=%0d", d,
                 {bus.delta_valid, bus.delta_ovf, bus.delta}, (d == 19) ? 4 : 2);
      end
    end
    drain("stall_merge", 1'b0);
    idle();
  endtask

  task automatic test_boundary_tick();
    int d;
    exp_q.push_back({1'b0, 3'd3});
    exp_q.push_back({1'b0, 3'd0});
    for (int c = -1; c <= 16; c++) begin
      cyc(c == 0 || c == 2 || c == 4, c <= 15, 1'b1, 1'b0);
      d = c + 1;
      n_cmp++;
      if (d == 8 || d == 16) begin
        if ({bus.delta_valid, bus.delta_ovf, bus.delta} !== {1'b1, 1'b0, (d == 8) ? 3'd3 : 3'd0}) begin
          n_bad++;
          $display("FAIL boundary cycle %0d: got v/ovf/delta=%b, expected valid=1 delta=%0d", d,
                   {bus.delta_valid, bus.delta_ovf, bus.delta}, (d == 8) ? 3 : 0);
        end
      end else if (bus.delta_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL boundary cycle %0d: got valid=%b, expected 0", d, bus.delta_valid);
      end
    end
    drain("boundary", 1'b0);
    idle();
  endtask

  task automatic test_enable_drop();
    int d;
    for (int c = -3; c <= 15; c++) begin
      cyc(c == -3 || c == -1 || c == 1 || c == 3 || c == 5, c >= -1 && c <= 5, 1'b1, 1'b0);
      n_cmp++;
      if (bus.delta_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL enable_drop cycle %0d: got valid=%b, expected 0", c + 1, bus.delta_valid);
      end
    end
    exp_q.push_back({1'b0, 3'd1});
    for (int c = -1; c <= 8; c++) begin
      cyc(c == 0, c <= 7, 1'b1, 1'b0);
      d = c + 1;
      n_cmp++;
      if (d == 8) begin
        if ({bus.delta_valid, bus.delta_ovf, bus.delta} !== {1'b1, 1'b0, 3'd1}) begin
          n_bad++;
          $display("FAIL reenable cycle %0d: got v/ovf/delta=%b, expected 10001", d,
                   {bus.delta_valid, bus.delta_ovf, bus.delta});
        end
      end else if (bus.delta_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL reenable cycle %0d: got valid=%b, expected 0", d, bus.delta_valid);
      end
    end
    drain("enable_drop", 1'b0);
    idle();
  endtask

  task automatic test_async_reset();
    int d;
    exp_q.push_back({1'b0, 3'd1});
    for (int c = -1; c <= 16; c++) begin
      cyc(c == -1 || c == 9, 1'b1, 1'b0, 1'b0);
      d = c + 1;
      if (d == 8 || d == 17) begin
        n_cmp++;
        if ({bus.delta_valid, bus.delta} !== {1'b1, 3'd1}) begin
          n_bad++;
          $display("FAIL pre_reset cycle %0d: got valid/delta=%b, expected 1001", d,
                   {bus.delta_valid, bus.delta});
        end
      end
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.delta_valid, bus.delta_ovf, bus.delta} !== 5'b0) begin
      n_bad++;
      $display("FAIL async_reset: got v/ovf/delta=%b, expected 00000",
               {bus.delta_valid, bus.delta_ovf, bus.delta});
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b1;
    idle();
    exp_q.push_back({1'b0, 3'd0});
    for (int c = -1; c <= 8; c++) begin
      cyc(1'b0, c <= 7, 1'b1, 1'b0);
      d = c + 1;
      n_cmp++;
      if (d == 8) begin
        if ({bus.delta_valid, bus.delta_ovf, bus.delta} !== 5'b10000) begin
          n_bad++;
          $display("FAIL post_reset cycle %0d: got v/ovf/delta=%b, expected 10000", d,
                   {bus.delta_valid, bus.delta_ovf, bus.delta});
        end
      end else if (bus.delta_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL post_reset cycle %0d: got valid=%b, expected 0", d, bus.delta_valid);
      end
    end
    drain("async_reset", 1'b0);
    idle();
  endtask

  initial begin
    test_reset();
    test_basic_window();
    test_saturation();
    test_stall_merge();
    test_boundary_tick();
    test_enable_drop();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
